// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: the machine word and the fetch-controller state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Redirect target as seen by a deferred flush: the resolved direction picks the path.
  function automatic lc3b_word flush_target(input logic br, input lc3b_word tgt_t,
                                            input lc3b_word tgt_nt);
    return br ? tgt_t : tgt_nt;
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {WIDTH{1'b1}}))
      cnt <= cnt + ONE;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: sequences PC loads, the I-cache read port and IF/ID valid,
// deferring mispredict redirects that arrive while an I-cache read is outstanding.
module fetch_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_resp,
  output logic             icache_read,
  input  logic             stall,
  input  logic             pred_taken,
  input  logic             flush_req,
  input  logic             flush_br,
  input  lc3b_word         flush_tgt_t,
  input  lc3b_word         flush_tgt_nt,
  output logic             pc_load,
  output logic             pc_flush,
  output logic             pc_br_sig,
  output lc3b_word         pc_flush_pc,
  output logic             pc_pred_taken,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] mispredict_cnt
);

  fetch_state_t state;
  lc3b_word     pend_pc;
  lc3b_word     flush_sel;

  assign flush_sel = flush_target(flush_br, flush_tgt_t, flush_tgt_nt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST;
      pend_pc <= '0;
    end else begin
      case (state)
        RST: state <= FETCH;
        FETCH: begin
          if (flush_req && !icache_resp) begin
            pend_pc <= flush_sel;
            state   <= DRAIN;
          end else if (icache_resp && !flush_req && stall) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (flush_req || !stall)
            state <= FETCH;
        end
        DRAIN: begin
          // The read in flight cannot be cancelled; the newest redirect wins.
          if (icache_resp)
            state <= FETCH;
          else if (flush_req)
            pend_pc <= flush_sel;
        end
        default: state <= RST;
      endcase
    end
  end

  always_comb begin
    icache_read   = 1'b0;
    pc_load       = 1'b0;
    pc_flush      = 1'b0;
    pc_br_sig     = 1'b0;
    pc_flush_pc   = '0;
    pc_pred_taken = 1'b0;
    ifid_valid    = 1'b0;
    case (state)
      FETCH: begin
        icache_read = 1'b1;
        if (icache_resp && flush_req) begin
          pc_load     = 1'b1;
          pc_flush    = 1'b1;
          pc_br_sig   = flush_br;
          pc_flush_pc = flush_tgt_nt;
        end else if (icache_resp && !stall) begin
          pc_load       = 1'b1;
          pc_pred_taken = pred_taken;
          ifid_valid    = 1'b1;
        end
      end
      HOLD: begin
        if (flush_req) begin
          pc_load     = 1'b1;
          pc_flush    = 1'b1;
          pc_br_sig   = flush_br;
          pc_flush_pc = flush_tgt_nt;
        end
      end
      DRAIN: begin
        icache_read = 1'b1;
        // Drained instruction is wrong-path; redirect with an explicit PC value.
        if (icache_resp) begin
          pc_load     = 1'b1;
          pc_flush    = 1'b1;
          pc_flush_pc = flush_req ? flush_sel : pend_pc;
        end
      end
      default: ;
    endcase
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_mispredict_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_req && (state != RST)),
    .cnt (mispredict_cnt)
  );

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller that sequences the PC register, the instruction-cache read port and the IF/ID valid bit. It holds an in-flight I-cache transaction open, decides on each cycle whether the PC loads a predicted, sequential or redirect value, and defers mispredict flushes that arrive mid-transaction until the transaction retires. It also keeps a saturating mispredict counter for performance analysis.

## Interface
Parameters:
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- icache_resp  in  1  I-cache read complete this cycle.
- icache_read  out  1  I-cache read request, held high until icache_resp.
- stall  in  1  IF/ID cannot accept an instruction this cycle (hazard/downstream stall).
- pred_taken  in  1  predictor says current fetch is a taken branch.
- flush_req  in  1  MEM-stage mispredict, valid for one cycle only.
- flush_br  in  1  resolved direction of the mispredicted branch (1 = taken).
- flush_tgt_t  in  lc3b_word  taken target (pcmux_out) at flush time.
- flush_tgt_nt  in  lc3b_word  fall-through PC at flush time.
- pc_load  out  1  PC register load.
- pc_flush  out  1  PC register flush select.
- pc_br_sig  out  1  PC flush direction select.
- pc_flush_pc  out  lc3b_word  PC flush (not-taken-path) value.
- pc_pred_taken  out  1  PC register loads predicted target.
- ifid_valid  out  1  fetched instruction is written into IF/ID as valid.
- mispredict_cnt  out  CNT_W  number of flush_req pulses since reset, saturating.

## Operation
- States: RST, FETCH, HOLD, DRAIN.
- RST: entered on rst. All outputs 0, mispredict_cnt = 0, pending registers = 0. Leaves for FETCH on the first clock edge after rst deasserts.
- FETCH: icache_read=1. Outcomes:
  - No icache_resp, no flush_req: stay.
  - icache_resp, no flush_req, !stall: pc_load=1, pc_pred_taken=pred_taken, ifid_valid=1. Stay in FETCH.
  - icache_resp, no flush_req, stall: pc_load=0, ifid_valid=0. Go to HOLD.
  - flush_req with icache_resp in the same cycle: immediate flush. Drive pc_load=1, pc_flush=1, pc_br_sig=flush_br, pc_flush_pc=flush_tgt_nt, ifid_valid=0 (wrong-path instruction discarded). Stay in FETCH.
  - flush_req without icache_resp: capture the target (flush_br ? flush_tgt_t : flush_tgt_nt) into pend_pc. Go to DRAIN.
- HOLD: icache_read=0.
  - !stall: go to FETCH. The same PC is re-read, so the instruction is not lost.
  - flush_req: immediate flush as above (pc_load=1, pc_flush=1, pc_br_sig=flush_br, pc_flush_pc=flush_tgt_nt). Go to FETCH. This takes priority over !stall.
- DRAIN: icache_read=1. The outstanding transaction cannot be aborted.
  - On icache_resp: ifid_valid=0, pc_load=1, pc_flush=1, pc_br_sig=0, pc_flush_pc=pend_pc. Go to FETCH.
  - A further flush_req in DRAIN overwrites pend_pc (the latest redirect wins). If it coincides with icache_resp, the new target is used directly.
- pc_pred_taken is 1 only on a non-flush pc_load. pc_flush is never asserted together with pc_pred_taken.
- mispredict_cnt increments by 1 on every flush_req cycle, in any non-RST state. It saturates at all-ones.

## Timing
- All control outputs are combinational from state and current inputs (Mealy). They are valid in the same cycle as icache_resp or flush_req. The PC changes on that cycle's rising edge.
- Fetch latency equals I-cache latency. There is no added bubble on a hit-and-accept.
- Immediate-flush redirect penalty is 0 cycles. A deferred flush costs the remaining I-cache latency.
- Asserting rst mid-transaction returns to RST immediately and drops icache_read. The I-cache owner tolerates an abandoned request.
- pend_pc and mispredict_cnt are registered. Counter reset value is 0.

## Structure
- fetch_state_t enum (RST, FETCH, HOLD, DRAIN) goes in lc3b_types alongside lc3b_word.
- One sub-module: sat_counter (parameterised width, inc, async reset) for mispredict_cnt.
- The FSM, pend_pc register and output decode live in fetch_ctrl itself.

## Test plan
- Reset: assert rst mid-FETCH. All outputs drop to 0 asynchronously. One cycle after release, icache_read=1.
- Streaming hits: icache_resp every 2nd cycle with stall=0, pred_taken=0. Expect pc_load=1 and ifid_valid=1 on each resp, and pc_pred_taken=0.
- Stall: resp with stall=1, then stall low 3 cycles later. Expect HOLD with icache_read=0, then a re-fetch and ifid_valid=1 on the next resp.
- Flush coincident with resp: flush_br=1, flush_tgt_t=0x1234. Expect pc_flush=1, pc_br_sig=1, ifid_valid=0 in the same cycle.
- Deferred flush: flush_req with flush_br=0, flush_tgt_nt=0x0A02, resp 2 cycles later. Expect that resp to give pc_flush=1, pc_br_sig=0, pc_flush_pc=0x0A02, ifid_valid=0.
- Counter: with CNT_W=2, apply 5 flush_req pulses. Expect mispredict_cnt to saturate at 3.
